// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter and receivers.
// Contents: transmitter state encoding, err_code values, common command bytes,
// device response codes and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StWaitDev,
        StSend,
        StAckWait,
        StDone,
        StError
    } ps2_tx_state_e;

    localparam logic [1:0] ERR_NONE          = 2'b00;
    localparam logic [1:0] ERR_START_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_XFER_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_NO_ACK        = 2'b11;

    localparam logic [7:0] CMD_RESET         = 8'hFF;
    localparam logic [7:0] CMD_ENABLE_REPORT = 8'hF4;
    localparam logic [7:0] CMD_SET_LEDS      = 8'hED;

    localparam logic [7:0] DEV_ACK           = 8'hFA;

    // PS/2 frames carry odd parity: the bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer plus falling-edge detector for one PS/2 line.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   pin   - raw bus line (open-drain, idles high)
//   level - synchronized line level
//   fall  - high for one cycle when the synchronized level goes 1 -> 0
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Flops reset to 1 so an idle (pulled-up) bus never shows a spurious edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= pin;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter. Performs the request-to-send
// handshake (clock inhibit, start bit), then shifts out 8 data bits LSB first,
// odd parity and stop on device-generated falling clock edges, and checks the
// device ACK on the 11th edge.
// Optional feature: define PS2_HOST_TX_RETRY_EN to retry once, silently, after
// a transfer timeout or missing ACK (start timeouts never retry).
// Ports:
//   CLOCK_50   - system clock
//   reset      - asynchronous active-high reset
//   send_cmd   - one-cycle start strobe, ignored while busy
//   cmd_byte   - byte to send, captured when send_cmd is accepted
//   PS2_CLK    - open-drain clock line (drives 0 or Z)
//   PS2_DAT    - open-drain data line (drives 0 or Z)
//   busy       - transmission in progress
//   rx_inhibit - copy of busy, gates the paired receiver
//   cmd_sent   - one-cycle pulse on device ACK
//   tx_error   - one-cycle pulse on failure, err_code valid alongside
//   err_code   - 01 start timeout, 10 transfer timeout, 11 no ACK; holds value
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES   = 5000,
    parameter int unsigned RTS_SETUP_CYCLES = 20,
    parameter int unsigned START_TIMEOUT    = 750000,
    parameter int unsigned XFER_TIMEOUT     = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       send_cmd,
    input  logic [7:0] cmd_byte,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic       busy,
    output logic       rx_inhibit,
    output logic       cmd_sent,
    output logic       tx_error,
    output logic [1:0] err_code
);

    // One phase counter serves INHIBIT, RTS and WAIT_DEV; size it for the longest.
    localparam int unsigned CntMax0 =
        (INHIBIT_CYCLES > RTS_SETUP_CYCLES) ? INHIBIT_CYCLES : RTS_SETUP_CYCLES;
    localparam int unsigned CntMax  = (START_TIMEOUT > CntMax0) ? START_TIMEOUT : CntMax0;
    localparam int unsigned CntW    = $clog2(CntMax + 1);
    localparam int unsigned XferW   = $clog2(XFER_TIMEOUT + 1);

    ps2_tx_state_e    state_q;
    logic [CntW-1:0]  cnt_q;
    logic [XferW-1:0] xfer_q;
    logic [3:0]       edge_q;
    logic [9:0]       shift_q;   // {stop, parity, data[7:0]}, shifted out from bit 0
    logic [7:0]       cmd_q;
    logic             clk_oe_q;
    logic             dat_oe_q;
    logic             busy_q;
    logic             cmd_sent_q;
    logic             tx_error_q;
    logic [1:0]       err_code_q;

    logic clk_level;
    logic clk_fall;
    logic dat_level;
    logic dat_fall;

    logic       fail;
    logic [1:0] fail_code;
    logic       retry;

    assign PS2_CLK = clk_oe_q ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_oe_q ? 1'b0 : 1'bz;

    ps2_line_sync u_clk_sync (
        .clk   (CLOCK_50),
        .rst   (reset),
        .pin   (PS2_CLK),
        .level (clk_level),
        .fall  (clk_fall)
    );

    // dat_fall is unused here; the same block serves the receivers.
    ps2_line_sync u_dat_sync (
        .clk   (CLOCK_50),
        .rst   (reset),
        .pin   (PS2_DAT),
        .level (dat_level),
        .fall  (dat_fall)
    );

    // Failure decode, kept apart from the FSM so the retry decision sees it.
    always_comb begin
        fail      = 1'b0;
        fail_code = ERR_NONE;
        case (state_q)
            StWaitDev: begin
                if (!clk_fall && cnt_q == CntW'(START_TIMEOUT - 1)) begin
                    fail      = 1'b1;
                    fail_code = ERR_START_TIMEOUT;
                end
            end
            StSend: begin
                if (xfer_q == XferW'(XFER_TIMEOUT - 1)) begin
                    fail      = 1'b1;
                    fail_code = ERR_XFER_TIMEOUT;
                end else if (clk_fall && edge_q == 4'd10 && dat_level) begin
                    fail      = 1'b1;
                    fail_code = ERR_NO_ACK;
                end
            end
            StAckWait: begin
                if (!(clk_level && dat_level) && xfer_q == XferW'(XFER_TIMEOUT - 1)) begin
                    fail      = 1'b1;
                    fail_code = ERR_XFER_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

`ifdef PS2_HOST_TX_RETRY_EN
    logic retry_used_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            retry_used_q <= 1'b0;
        end else if (state_q == StIdle && send_cmd) begin
            retry_used_q <= 1'b0;
        end else if (retry) begin
            retry_used_q <= 1'b1;
        end
    end

    assign retry = fail && (fail_code != ERR_START_TIMEOUT) && !retry_used_q;
`else
    assign retry = 1'b0;
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            xfer_q     <= '0;
            edge_q     <= '0;
            shift_q    <= '0;
            cmd_q      <= '0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            cmd_sent_q <= 1'b0;
            tx_error_q <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            cmd_sent_q <= 1'b0;
            tx_error_q <= 1'b0;
            if (retry) begin
                // Restart the handshake with the captured byte; busy stays high.
                state_q  <= StInhibit;
                cnt_q    <= '0;
                clk_oe_q <= 1'b1;
                dat_oe_q <= 1'b0;
                shift_q  <= {1'b1, odd_parity(cmd_q), cmd_q};
            end else if (fail) begin
                state_q    <= StError;
                clk_oe_q   <= 1'b0;
                dat_oe_q   <= 1'b0;
                tx_error_q <= 1'b1;
                err_code_q <= fail_code;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (send_cmd) begin
                            cmd_q    <= cmd_byte;
                            shift_q  <= {1'b1, odd_parity(cmd_byte), cmd_byte};
                            busy_q   <= 1'b1;
                            clk_oe_q <= 1'b1;
                            cnt_q    <= '0;
                            state_q  <= StInhibit;
                        end
                    end
                    StInhibit: begin
                        if (cnt_q == CntW'(INHIBIT_CYCLES - 1)) begin
                            cnt_q    <= '0;
                            dat_oe_q <= 1'b1;   // start bit
                            state_q  <= StRts;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StRts: begin
                        if (cnt_q == CntW'(RTS_SETUP_CYCLES - 1)) begin
                            cnt_q    <= '0;
                            clk_oe_q <= 1'b0;
                            state_q  <= StWaitDev;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StWaitDev: begin
                        if (clk_fall) begin
                            // First device edge: present data[0], start transfer timer.
                            dat_oe_q <= ~shift_q[0];
                            shift_q  <= {1'b1, shift_q[9:1]};
                            edge_q   <= 4'd1;
                            xfer_q   <= '0;
                            state_q  <= StSend;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StSend: begin
                        xfer_q <= xfer_q + 1'b1;
                        if (clk_fall) begin
                            if (edge_q == 4'd10) begin
                                // 11th edge with DAT low (high was caught as a failure).
                                state_q <= StAckWait;
                            end else begin
                                dat_oe_q <= ~shift_q[0];
                                shift_q  <= {1'b1, shift_q[9:1]};
                                edge_q   <= edge_q + 4'd1;
                            end
                        end
                    end
                    StAckWait: begin
                        xfer_q <= xfer_q + 1'b1;
                        if (clk_level && dat_level) begin
                            cmd_sent_q <= 1'b1;
                            state_q    <= StDone;
                        end
                    end
                    StDone: begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                    StError: begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign busy       = busy_q;
    assign rx_inhibit = busy_q;
    assign cmd_sent   = cmd_sent_q;
    assign tx_error   = tx_error_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on the bus.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned INH   = 50;
    localparam int unsigned RTS   = 8;
    localparam int unsigned START = 400;
    localparam int unsigned XFER  = 2000;
    localparam int          HALF  = 20;
    localparam int          BOUND = 20000;
`ifdef PS2_HOST_TX_RETRY_EN
    localparam int          TRIES = 2;
`else
    localparam int          TRIES = 1;
`endif

    // Device modes: 0 ACK, 1 no ACK, 2 stop after 4 edges, 3 stop after 5 edges.
    typedef struct {
        logic [7:0] cmd;
        int         mode;
        bit         poke;
        logic       exp_par;
        logic [1:0] exp_code;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       send_cmd;
    logic [7:0] cmd_byte;
    wire        ps2_clk;
    wire        ps2_dat;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       busy, rx_inhibit, cmd_sent, tx_error;
    logic [1:0] err_code;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_host_tx #(
        .INHIBIT_CYCLES   (INH),
        .RTS_SETUP_CYCLES (RTS),
        .START_TIMEOUT    (START),
        .XFER_TIMEOUT     (XFER)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .send_cmd   (send_cmd),
        .cmd_byte   (cmd_byte),
        .PS2_CLK    (ps2_clk),
        .PS2_DAT    (ps2_dat),
        .busy       (busy),
        .rx_inhibit (rx_inhibit),
        .cmd_sent   (cmd_sent),
        .tx_error   (tx_error),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Device-model observations
    logic [9:0] dev_bits;
    int         dev_low_len;
    logic       dev_start;
    int         first_fall_cyc;
    int         inhibits;

    // Watcher observations
    int         w_sent, w_errs, w_err_cyc, w_bad_busy, w_bad_inh, w_both;
    logic [1:0] w_code;
    bit         w_tmo;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Returns with send_cmd accepted on the posedge just passed.
    task automatic send(input logic [7:0] b);
        send_cmd = 1'b1;
        cmd_byte = b;
        tick();
        send_cmd = 1'b0;
        cmd_byte = 8'h00;
    endtask

    task automatic device_frame(input int mode);
        int n;
        n           = 0;
        dev_bits    = '0;
        dev_low_len = 0;
        dev_start   = 1'b1;
        while (ps2_clk !== 1'b0 && n < BOUND) begin
            tick();
            n++;
        end
        if (n >= BOUND) return;
        inhibits++;
        while (ps2_clk === 1'b0 && dev_low_len < BOUND) begin
            tick();
            dev_low_len++;
        end
        dev_start = ps2_dat;
        repeat (10) tick();
        for (int e = 1; e <= 11; e++) begin
            if (mode == 2 && e == 5) return;
            if (mode == 3 && e == 6) return;
            dev_clk_low = 1'b1;
            if (e == 1) first_fall_cyc = cyc;
            repeat (HALF) tick();
            if (e <= 10) dev_bits[e-1] = ps2_dat;
            dev_clk_low = 1'b0;
            repeat (HALF / 2) tick();
            if (e == 10 && mode == 0) dev_dat_low = 1'b1;
            repeat (HALF / 2) tick();
        end
        if (mode == 0) begin
            repeat (HALF) tick();
            dev_dat_low = 1'b0;
        end
    endtask

    // Samples outputs on falling edges until busy drops.
    task automatic watch();
        int   n;
        logic prev_sent;
        n = 0; prev_sent = 1'b0;
        w_sent = 0; w_errs = 0; w_err_cyc = 0; w_bad_busy = 0; w_bad_inh = 0; w_both = 0;
        w_code = 2'b00; w_tmo = 1'b1;
        while (n < BOUND) begin
            @(negedge clk);
            n++;
            if (rx_inhibit !== busy) w_bad_inh++;
            if (cmd_sent === 1'b1 && tx_error === 1'b1) w_both++;
            if (prev_sent && busy !== 1'b0) w_bad_busy++;
            if (cmd_sent === 1'b1) w_sent++;
            if (tx_error === 1'b1) begin
                w_errs++;
                w_code    = err_code;
                w_err_cyc = cyc;
            end
            prev_sent = cmd_sent;
            if (busy === 1'b0) begin
                w_tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   tries, low0;
        logic start0;
        v      = vecs[i];
        tries  = (v.mode == 0) ? 1 : TRIES;
        inhibits = 0;
        low0   = 0;
        start0 = 1'b1;
        send(v.cmd);
        fork
            begin
                for (int t = 0; t < tries; t++) begin
                    device_frame(v.mode);
                    if (t == 0) begin
                        low0   = dev_low_len;
                        start0 = dev_start;
                    end
                end
            end
            watch();
            begin
                if (v.poke) begin
                    repeat (200) tick();
                    send(8'h00);
                end
            end
        join
        check($sformatf("v%0d timeout", i), w_tmo, 1'b0);
        check($sformatf("v%0d sent", i), w_sent, (v.mode == 0) ? 1 : 0);
        check($sformatf("v%0d err_count", i), w_errs, (v.mode == 0) ? 0 : 1);
        if (v.mode != 0) check($sformatf("v%0d err_code", i), w_code, v.exp_code);
        check($sformatf("v%0d inhibit_len_ok", i), low0 >= int'(INH), 1'b1);
        check($sformatf("v%0d start_bit", i), start0, 1'b0);
        check($sformatf("v%0d inhibits", i), inhibits, tries);
        if (v.mode != 2) begin
            check($sformatf("v%0d data", i), dev_bits[7:0], v.cmd);
            check($sformatf("v%0d parity", i), dev_bits[8], v.exp_par);
            check($sformatf("v%0d stop", i), dev_bits[9], 1'b1);
        end else begin
            check_range($sformatf("v%0d xfer_delay", i), w_err_cyc - first_fall_cyc,
                        XFER + 2, XFER + 4);
        end
        check($sformatf("v%0d busy_after_sent", i), w_bad_busy, 0);
        check($sformatf("v%0d rx_inhibit", i), w_bad_inh, 0);
        check($sformatf("v%0d sent_and_err", i), w_both, 0);
        repeat (5) tick();
    endtask

    initial begin
        int acc;
        vecs[0] = '{cmd: CMD_ENABLE_REPORT, mode: 0, poke: 0, exp_par: 1'b0, exp_code: 2'b00};
        vecs[1] = '{cmd: CMD_SET_LEDS,      mode: 0, poke: 0, exp_par: 1'b1, exp_code: 2'b00};
        vecs[2] = '{cmd: 8'h00,             mode: 0, poke: 0, exp_par: 1'b1, exp_code: 2'b00};
        vecs[3] = '{cmd: CMD_RESET,         mode: 0, poke: 0, exp_par: 1'b1, exp_code: 2'b00};
        vecs[4] = '{cmd: CMD_ENABLE_REPORT, mode: 0, poke: 1, exp_par: 1'b0, exp_code: 2'b00};
        vecs[5] = '{cmd: CMD_SET_LEDS,      mode: 1, poke: 0, exp_par: 1'b1, exp_code: 2'b11};
        vecs[6] = '{cmd: 8'h5A,             mode: 2, poke: 0, exp_par: 1'b1, exp_code: 2'b10};

        rst      = 1'b1;
        send_cmd = 1'b0;
        cmd_byte = 8'h00;
        repeat (3) tick();
        check("reset busy", busy, 1'b0);
        check("reset rx_inhibit", rx_inhibit, 1'b0);
        check("reset cmd_sent", cmd_sent, 1'b0);
        check("reset tx_error", tx_error, 1'b0);
        check("reset err_code", err_code, 2'b00);
        check("reset clk_line", ps2_clk, 1'b1);
        check("reset dat_line", ps2_dat, 1'b1);
        rst = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 7; i++) run_vec(i);

        // Device never clocks: start timeout, never retried.
        send(CMD_ENABLE_REPORT);
        acc = cyc;
        watch();
        check("start_tmo timeout", w_tmo, 1'b0);
        check("start_tmo err_count", w_errs, 1);
        check("start_tmo err_code", w_code, ERR_START_TIMEOUT);
        check("start_tmo delay", w_err_cyc - acc, INH + RTS + START);
        check("start_tmo clk_line", ps2_clk, 1'b1);
        check("start_tmo dat_line", ps2_dat, 1'b1);
        repeat (5) tick();

        // Reset while the host drives data[4]=0 during bit 5.
        send(8'h00);
        device_frame(3);
        check("midreset dat_driven", ps2_dat, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midreset clk_line", ps2_clk, 1'b1);
        check("midreset dat_line", ps2_dat, 1'b1);
        check("midreset busy", busy, 1'b0);
        check("midreset rx_inhibit", rx_inhibit, 1'b0);
        check("midreset cmd_sent", cmd_sent, 1'b0);
        check("midreset tx_error", tx_error, 1'b0);
        check("midreset err_code", err_code, 2'b00);
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // Recovery after the aborted transfer.
        run_vec(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
